// File: rtl/sha256_pkg.sv
// sha256_pkg: shared widths, host FSM states and SHA-256 initial hash words
package sha256_pkg;
    localparam int WORD_W       = 32;
    localparam int ADDR_W       = 16;
    localparam int DIGEST_WORDS = 8;

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, UNLOAD} state_t;

    // index 0 is h0
    localparam logic [DIGEST_WORDS-1:0][WORD_W-1:0] H_INIT = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };
endpackage

// File: rtl/sha256_sram.sv
// sha256_sram: single-port word SRAM, registered read-old data, out-of-range reads zero
module sha256_sram
    import sha256_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic              hit;

    assign hit = addr < ADDR_W'(DEPTH);

    // array write; addresses beyond the array are dropped
    always_ff @(posedge clk) begin
        if (we && hit) mem[addr[AW-1:0]] <= wdata;
    end

    // registered read sees the pre-write contents on a same-address write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdata <= '0;
        else if (re)  rdata <= hit ? mem[addr[AW-1:0]] : '0;
    end
endmodule

// File: rtl/sha256_mem_host.sv
// sha256_mem_host: host load/unload front-end and SRAM responder for the SHA-256 engine (watchdog: SHA_MEM_HOST_TIMEOUT_EN)
module sha256_mem_host
    import sha256_pkg::*;
#(
    parameter int          NUM_OF_WORDS   = 20,
    parameter int          DEPTH          = 64,
    parameter logic [15:0] MSG_BASE       = 16'h0000,
    parameter logic [15:0] OUT_BASE       = 16'h0020,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        start,
    input  logic        done,
    output logic [15:0] message_addr,
    output logic [15:0] output_addr,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        err
);
    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  rd_idx;
    logic [2:0]  fetch_idx;
    logic        own;
    logic        acc;
    logic        fetch;
    logic        last_eng;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_q;
    logic [31:0] hold_q;
`ifdef SHA_MEM_HOST_TIMEOUT_EN
    logic [15:0] wdog;
`endif

    assign message_addr = MSG_BASE;
    assign output_addr  = OUT_BASE;
    assign own          = state inside {START, WAIT_BUSY, WAIT_DONE};
    assign acc          = in_valid & in_ready;
    // prefetch the first digest word on entry, then the next one on each non-final handshake
    assign fetch        = (state == UNLOAD) && (!out_valid || (out_ready && !out_last));
    assign fetch_idx    = out_valid ? rd_idx + 3'd1 : rd_idx;
    assign out_data     = sram_q;
    assign mem_read_data = last_eng ? sram_q : hold_q;

    // engine owns the port while it runs; otherwise host writes or digest prefetch reads
    always_comb begin
        sram_we    = own ? mem_we : acc;
        sram_addr  = own ? mem_addr : fetch ? OUT_BASE + 16'(fetch_idx)
                   : (state == IDLE) ? MSG_BASE : MSG_BASE + cnt;
        sram_wdata = own ? mem_write_data : in_data;
    end

    sha256_sram #(.DEPTH(DEPTH)) u_sram (
        .clk    (clk),
        .reset_n(reset_n),
        .re     (own | fetch),
        .we     (sram_we),
        .addr   (sram_addr),
        .wdata  (sram_wdata),
        .rdata  (sram_q)
    );

    // keep the last engine read visible once the host starts reusing the read register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_eng <= 1'b1;
            hold_q   <= '0;
        end else begin
            if (last_eng) hold_q <= sram_q;
            if (own)        last_eng <= 1'b1;
            else if (fetch) last_eng <= 1'b0;
        end
    end

    // control FSM with registered handshake, start and error outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            start     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            rd_idx    <= '0;
`ifdef SHA_MEM_HOST_TIMEOUT_EN
            wdog      <= '0;
`endif
        end else begin
            start <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (acc) begin
                        cnt <= 16'd1;
                        err <= (NUM_OF_WORDS == 1) ? !in_last : in_last;
                        if (NUM_OF_WORDS == 1) begin
                            state    <= START;
                            start    <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (!in_last) state <= LOAD;
                    end
                end
                LOAD: begin
                    if (acc) begin
                        cnt <= cnt + 16'd1;
                        if (cnt == 16'(NUM_OF_WORDS - 1)) begin
                            state    <= START;
                            start    <= 1'b1;
                            in_ready <= 1'b0;
                            err      <= err | !in_last;
                        end else if (in_last) begin
                            state <= IDLE;
                            err   <= 1'b1;
                        end
                    end
                end
                START: begin
                    state <= WAIT_BUSY;
`ifdef SHA_MEM_HOST_TIMEOUT_EN
                    wdog  <= '0;
`endif
                end
                WAIT_BUSY: if (!done) state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (done) begin
                        state  <= UNLOAD;
                        rd_idx <= '0;
                    end
                end
                UNLOAD: begin
                    if (!out_valid) out_valid <= 1'b1;
                    else if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            rd_idx   <= rd_idx + 3'd1;
                            out_last <= rd_idx == 3'(DIGEST_WORDS - 2);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef SHA_MEM_HOST_TIMEOUT_EN
            if (state == WAIT_BUSY || state == WAIT_DONE) begin
                if (wdog == 16'(TIMEOUT_CYCLES - 1)) begin
                    state    <= IDLE;
                    err      <= 1'b1;
                    in_ready <= 1'b1;
                end else wdog <= wdog + 16'd1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_sha256_mem_host.sv
// tb_sha256_mem_host: directed scoreboard bench with a stub engine driving the memory port
module tb_sha256_mem_host;
    import sha256_pkg::*;

    localparam int          NW = 20;
    localparam logic [15:0] MB = 16'h0000;
    localparam logic [15:0] OB = 16'h0020;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        done = 1'b1;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [31:0] mem_write_data = '0;
    logic        in_ready, out_valid, out_last, start, err;
    logic [31:0] out_data, mem_read_data;
    logic [15:0] message_addr, output_addr;

    int          n_chk = 0;
    int          n_fail = 0;
    int          start_cnt = 0;
    bit          ov_seen = 1'b0;
    logic [31:0] rd_q[$];
    logic [31:0] dg_q[$];

    sha256_mem_host #(
        .NUM_OF_WORDS(NW), .DEPTH(64), .MSG_BASE(MB), .OUT_BASE(OB), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .start(start), .done(done), .message_addr(message_addr), .output_addr(output_addr),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start) start_cnt++;
        if (out_valid) ov_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int w = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic load(input logic [31:0] base, input int n, input int last_at);
        for (int i = 0; i < n; i++) send(base + 32'(i), i == last_at);
    endtask

    task automatic eng_read(input string tag, input logic [15:0] a, input logic [31:0] exp);
        mem_addr = a;
        rd_q.push_back(exp);
        @(negedge clk);
        chk(tag, mem_read_data, rd_q.pop_front());
    endtask

    task automatic engine_run(input logic [31:0] mbase, input bit use_h);
        logic [31:0] d;
        chk("start_pulse", {31'd0, start}, 32'd1);
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        done = 1'b0;
        for (int i = 0; i < NW; i++) eng_read("eng_read", MB + 16'(i), mbase + 32'(i));
        eng_read("oob_read", 16'h0050, 32'h0);
        mem_we = 1'b1;
        mem_write_data = 32'hBAD0BAD0;
        mem_addr = 16'h0050;
        @(negedge clk);
        mem_we = 1'b0;
        eng_read("oob_alias", MB + 16'd16, mbase + 32'd16);
        eng_read("oob_reread", 16'h0050, 32'h0);
        mem_we = 1'b1;
        mem_write_data = 32'hDEAD0000;
        eng_read("read_old", MB, mbase);
        mem_we = 1'b0;
        eng_read("read_new", MB, 32'hDEAD0000);
        for (int k = 0; k < DIGEST_WORDS; k++) begin
            d = use_h ? H_INIT[k] : 32'hA0 + 32'(k);
            mem_we = 1'b1;
            mem_addr = OB + 16'(k);
            mem_write_data = d;
            dg_q.push_back(d);
            @(negedge clk);
        end
        mem_we = 1'b0;
        done = 1'b1;
        @(negedge clk);
        chk("unload_entry_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("first_valid", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic unload(input logic [3:0] pat);
        int got = 0;
        int cyc = 0;
        logic [31:0] prev = '0;
        bit stalled = 1'b0;
        while (got < DIGEST_WORDS && cyc < 100) begin
            out_ready = pat[2'(cyc)];
            if (stalled) chk("stall_hold", out_data, prev);
            if (out_valid && out_ready) begin
                chk("digest", out_data, dg_q.pop_front());
                chk("out_last", {31'd0, out_last}, {31'd0, got == DIGEST_WORDS - 1});
                got++;
            end
            stalled = out_valid && !out_ready;
            prev = out_data;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("unload_count", 32'(got), 32'(DIGEST_WORDS));
        chk("post_unload_valid", {31'd0, out_valid}, 32'd0);
        chk("post_unload_idle", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", mem_read_data, 32'd0);
        chk("message_addr", {16'd0, message_addr}, {16'd0, MB});
        chk("output_addr", {16'd0, output_addr}, {16'd0, OB});
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // reset in the middle of a load
        load(32'd1, 5, -1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_in_ready", {31'd0, in_ready}, 32'd0);
        chk("async_start", {31'd0, start}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {31'd0, in_ready}, 32'd1);
        chk("no_start_after_reset", 32'(start_cnt), 32'd0);

        // nominal message and digest
        load(32'd1, NW, NW - 1);
        chk("start_not_yet", 32'(start_cnt), 32'd0);
        engine_run(32'd1, 1'b0);
        chk("start_once", 32'(start_cnt), 32'd1);
        unload(4'b1111);
        chk("nominal_err", {31'd0, err}, 32'd0);

        // early in_last aborts the load
        load(32'h40, 7, 6);
        chk("early_last_err", {31'd0, err}, 32'd1);
        chk("early_last_idle", {31'd0, in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("early_last_no_start", 32'(start_cnt), 32'd1);

        // next load clears err, then unload under backpressure
        send(32'h100, 1'b0);
        chk("err_cleared", {31'd0, err}, 32'd0);
        for (int i = 1; i < NW; i++) send(32'h100 + 32'(i), i == NW - 1);
        engine_run(32'h100, 1'b1);
        chk("start_twice", 32'(start_cnt), 32'd2);
        unload(4'b1001);
        chk("bp_err", {31'd0, err}, 32'd0);

`ifdef SHA_MEM_HOST_TIMEOUT_EN
        // engine never finishes
        begin
            int n = 0;
            load(32'h200, NW, NW - 1);
            chk("to_start", {31'd0, start}, 32'd1);
            done = 1'b0;
            ov_seen = 1'b0;
            while (!in_ready && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("to_cycles", 32'(n), 32'd101);
            chk("to_err", {31'd0, err}, 32'd1);
            chk("to_no_out", {31'd0, ov_seen}, 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sha256_mem_host.md
Name: sha256_mem_host

Overview:
Memory-side responder and host front-end for the SHA-256 engine. Owns the word-addressed message/digest SRAM and services the engine's memory request port with one-cycle read latency. Accepts a message from a host over a valid/ready stream and pulses start. Waits for the engine's done, then streams the 8-word digest back out. Sits between the system host and the engine.

Parameters:
NUM_OF_WORDS, 20, message length in 32-bit words; must be 1..DEPTH-8
DEPTH, 64, SRAM depth in 32-bit words
MSG_BASE, 16'h0000, word address where message word 0 is stored
OUT_BASE, 16'h0020, word address of digest word h0
TIMEOUT_CYCLES, 4096, watchdog limit; used only with the optional feature

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  host message word valid
in_ready  out  1  host message word accepted when valid&ready
in_data  in  32  message word
in_last  in  1  marks the final message word
out_valid  out  1  digest word valid
out_ready  in  1  host accepts digest word
out_data  out  32  digest word, h0 first
out_last  out  1  high with h7
start  out  1  one-cycle pulse to engine
done  in  1  engine idle/finished (high while engine idle)
message_addr  out  16  constant MSG_BASE
output_addr  out  16  constant OUT_BASE
mem_we  in  1  engine write enable
mem_addr  in  16  engine word address
mem_write_data  in  32  engine write data
mem_read_data  out  32  registered read data
err  out  1  sticky error flag; cleared on next accepted first word

Behaviour:
- Clock and reset: one clock (clk). Asynchronous active-low reset (reset_n).
- Reset values: state=IDLE; in_ready=0; out_valid=0; out_last=0; start=0; err=0; mem_read_data=0. SRAM contents undefined.
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, UNLOAD.
- IDLE: in_ready=1. The first accepted word clears err, is written to MSG_BASE, sets cnt=1, and moves to LOAD. If that word has in_last and NUM_OF_WORDS==1, go to START.
- LOAD: in_ready=1. Each accepted word is written to MSG_BASE+cnt and cnt increments.
  - Word NUM_OF_WORDS-1 accepted: go to START. If in_last is low on that word, set err but still proceed.
  - in_last on an earlier word: set err, return to IDLE, no start.
- START: start=1 for exactly one cycle; in_ready=0; go to WAIT_BUSY.
- WAIT_BUSY: wait for done==0.
- WAIT_DONE: wait for done==1, then go to UNLOAD with rd_idx=0.
- Engine port ownership:
  - Engine owns the SRAM in START, WAIT_BUSY and WAIT_DONE.
  - In other states, engine writes are dropped and mem_read_data holds its value.
- Engine read: mem_read_data <= mem[mem_addr] at posedge, i.e. data for the address presented in cycle N is valid in cycle N+1.
- Engine write: mem[mem_addr] <= mem_write_data at posedge when mem_we=1.
- Same-cycle read and write to one address: read returns the old data.
- mem_addr >= DEPTH: write dropped, read returns 32'h0.
- UNLOAD: reads OUT_BASE+rd_idx through a one-entry prefetch.
  - out_valid first rises one cycle after entry.
  - out_data is held stable while out_valid & !out_ready.
  - Back-to-back words sustain one per cycle under constant out_ready.
  - out_last=1 with rd_idx 7. Its handshake returns to IDLE.
- No host input is accepted outside IDLE/LOAD.
- Asynchronous reset mid-operation: returns to IDLE immediately, start deasserts. The engine is reset by the same reset_n.

Optional Feature:
Macro SHA_MEM_HOST_TIMEOUT_EN.
- Defined: a 16-bit watchdog counts cycles spent in WAIT_BUSY/WAIT_DONE. Reaching TIMEOUT_CYCLES sets err and returns to IDLE without unload.
- Undefined: no counter. The block waits indefinitely, and TIMEOUT_CYCLES is ignored.

Decomposition:
- Package sha256_pkg holds:
  - state enum type
  - WORD_W=32, ADDR_W=16, DIGEST_WORDS=8
  - the SHA-256 initial hash constants, for bench reuse
- Sub-module sha256_sram: single-port, DEPTH words, registered read, write-first disabled (read-old). The top-level block muxes engine and host access onto it.

Test Plan:
1. Reset mid-LOAD: assert reset_n=0 after word 5 -> in_ready=0 and start=0 asynchronously. After release, state is IDLE and a full reload works.
2. Nominal: load words 32'h00000001..32'h00000014 with in_last on word 20 -> start pulses exactly once, 1 cycle after the last handshake. A stub engine reads MSG_BASE..+19 and gets each value 1 cycle after its address. The stub writes 32'hA0..A7 to OUT_BASE..+7 and drops/raises done. The host then receives A0..A7 in order, out_last with A7, and err=0.
3. Early in_last on word 7 -> err=1, no start, back to IDLE. The next load clears err.
4. Backpressure: out_ready toggles 1,0,0,1 during UNLOAD -> out_data is stable while stalled; no word is lost or duplicated.
5. Out-of-range access: engine reads addr 16'h0050 with DEPTH=64 -> mem_read_data=0. A write to that address leaves all locations unchanged.
6. With SHA_MEM_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=100: the stub never raises done -> err=1 and state is IDLE at cycle 100 after start; out_valid never asserts.
